// File: rtl/uart_tx_16x.sv
// UART transmitter paced by a 16x oversampling baud tick: start bit, DBIT data bits LSB first,
// optional parity bit, then a stop period of SB_TICK ticks. Line output and done pulse are registered.
module uart_tx_16x #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam logic [4:0] LAST_TICK = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);
    localparam logic       ODD       = (PARITY == 2);

    state_t          r_state, w_state_next;
    logic [4:0]      r_s, w_s_next;
    logic [2:0]      r_n, w_n_next;
    logic [DBIT-1:0] r_b, w_b_next;
    logic            r_p, w_p_next;
    logic            r_tx, w_tx_next;
    logic            r_done, w_done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_p     <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_p     <= w_p_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
        end
    end

    // A tick arriving in the accepting cycle is deliberately not counted: IDLE ignores s_tick.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_p_next     = r_p;
        case (r_state)
            IDLE: begin
                if (tx_start) begin
                    w_b_next     = din;
                    w_s_next     = '0;
                    w_p_next     = 1'b0;
                    w_state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == LAST_TICK) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = DATA;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == LAST_TICK) begin
                        w_s_next = '0;
                        w_b_next = r_b >> 1;
                        w_p_next = r_p ^ r_b[0];
                        if (r_n == LAST_BIT) begin
                            w_state_next = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            w_n_next = r_n + 3'd1;
                        end
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            PAR: begin
                if (s_tick) begin
                    if (r_s == LAST_TICK) begin
                        w_s_next     = '0;
                        w_state_next = STOP;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_s == STOP_LAST) begin
                        w_s_next     = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_s_next     = '0;
            end
        endcase
    end

    // The line is driven from the upcoming state so tx changes on the same edge as the state.
    always_comb begin
        w_done_next = (r_state == STOP) && (w_state_next == IDLE);
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_b_next[0];
            PAR:     w_tx_next = w_p_next ^ ODD;
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx_busy      = (r_state != IDLE);
    assign tx_done_tick = r_done;
    assign tx           = r_tx;

endmodule

// File: tb/tb_uart_tx_16x.sv
// Bench for uart_tx_16x: four instances (no parity, even, odd, 2 stop bits) checked every cycle
// against a frame-level model, plus literal expectations on frame length and line contents.
module tb_uart_tx_16x;

    localparam int PAR_CFG [4] = '{0, 1, 2, 0};
    localparam int SB_CFG  [4] = '{16, 16, 16, 32};

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick  = 1'b1;
    logic [3:0] start_v = '0;
    logic [7:0] din_v [4];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;
    wire  [3:0] done_w;

    int n_checks = 0;
    int n_pass   = 0;
    logic cmp_en = 1'b0;
    int tick_m = 1;
    int tick_c = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            uart_tx_16x #(
                .DBIT    (8),
                .SB_TICK (SB_CFG[gi]),
                .PARITY  (PAR_CFG[gi])
            ) u_dut (
                .clk          (clk),
                .reset_n      (reset_n),
                .s_tick       (s_tick),
                .tx_start     (start_v[gi]),
                .din          (din_v[gi]),
                .tx_busy      (busy_w[gi]),
                .tx_done_tick (done_w[gi]),
                .tx           (tx_w[gi])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Frame model: the line is a list of bit values, each lasting 16 counted ticks, stop to the end.
    logic        m_busy  [4];
    logic        m_done  [4];
    int          m_ticks [4];
    int          m_nb    [4];
    logic [15:0] m_bits  [4];

    function automatic logic [15:0] frame_bits(input logic [7:0] v, input int par);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = v;
        if (par != 0) f[9] = (^v) ^ (par == 2);
        return f;
    endfunction

    function automatic logic exp_tx(input int i);
        int idx;
        if (!m_busy[i]) return 1'b1;
        idx = m_ticks[i] / 16;
        if (idx >= m_nb[i]) return 1'b1;
        return m_bits[i][idx];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i]  <= 1'b0;
                m_done[i]  <= 1'b0;
                m_ticks[i] <= 0;
                m_nb[i]    <= 9;
                m_bits[i]  <= '1;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_done[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (start_v[i]) begin
                        m_busy[i]  <= 1'b1;
                        m_ticks[i] <= 0;
                        m_bits[i]  <= frame_bits(din_v[i], PAR_CFG[i]);
                        m_nb[i]    <= (PAR_CFG[i] != 0) ? 10 : 9;
                    end
                end else if (s_tick) begin
                    m_ticks[i] <= m_ticks[i] + 1;
                    if (m_ticks[i] + 1 == 16 * m_nb[i] + SB_CFG[i]) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("d%0d_tx", i), 32'(tx_w[i]), 32'(exp_tx(i)));
                chk($sformatf("d%0d_busy", i), 32'(busy_w[i]), 32'(m_busy[i]));
                chk($sformatf("d%0d_done", i), 32'(done_w[i]), 32'(m_done[i]));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        tick_c = (tick_c + 1) % tick_m;
        s_tick = (tick_c == 0);
    endtask

    // Launch a frame on instance d and follow it until tx_done_tick; k counts edges after acceptance.
    task automatic send(input int d, input logic [7:0] v, input int poke_k, output int k_done,
                        output logic [15:0] mids, output int busy_cnt, output int low_run,
                        output logic tx0);
        int   k;
        logic seen_high;
        din_v[d]   = v;
        start_v[d] = 1'b1;
        cyc();
        start_v[d] = 1'b0;
        k = 0; busy_cnt = 0; low_run = 0; seen_high = 1'b0; mids = '0; k_done = -1;
        tx0 = tx_w[d];
        while (k < 3000) begin
            if (busy_w[d]) busy_cnt++;
            if (!seen_high && tx_w[d] == 1'b0) low_run++;
            else seen_high = 1'b1;
            if (k % 16 == 8 && k / 16 < 16) mids[k / 16] = tx_w[d];
            cyc();
            k++;
            if (k == poke_k) begin
                din_v[d]   = 8'hFF;
                start_v[d] = 1'b1;
            end else if (k == poke_k + 1) begin
                start_v[d] = 1'b0;
            end
            if (done_w[d]) begin
                k_done = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          kd, bc, lr;
        logic [15:0] md;
        logic        t0;
        for (int i = 0; i < 4; i++) din_v[i] = 8'h00;
        repeat (3) cyc();
        cmp_en = 1'b1;
        chk("rst_tx", 32'(tx_w), 32'hF);
        chk("rst_busy", 32'(busy_w), 32'h0);
        chk("rst_done", 32'(done_w), 32'h0);
        reset_n = 1'b1;
        repeat (3) cyc();

        // 8N1 frame, tick every cycle
        send(0, 8'hA5, -1, kd, md, bc, lr, t0);
        $display("frame d0 din=a5 done_at=%0d busy=%0d", kd, bc);
        chk("t1_len", kd, 160);
        chk("t1_busy_cycles", bc, 160);
        chk("t1_line", 32'(md[9:0]), 32'({1'b1, 8'hA5, 1'b0}));
        cyc();
        chk("t1_done_once", 32'(done_w[0]), 32'h0);
        repeat (3) cyc();

        // parity frames
        send(1, 8'hA5, -1, kd, md, bc, lr, t0);
        $display("frame d1 even din=a5 done_at=%0d parity=%0d", kd, md[9]);
        chk("t2_even_len", kd, 176);
        chk("t2_even_par", 32'(md[9]), 32'h0);
        chk("t2_even_stop", 32'(md[10]), 32'h1);
        repeat (3) cyc();
        send(2, 8'h01, -1, kd, md, bc, lr, t0);
        $display("frame d2 odd din=01 done_at=%0d parity=%0d", kd, md[9]);
        chk("t2_odd01_len", kd, 176);
        chk("t2_odd01_par", 32'(md[9]), 32'h0);
        repeat (3) cyc();
        send(2, 8'h03, -1, kd, md, bc, lr, t0);
        $display("frame d2 odd din=03 done_at=%0d parity=%0d", kd, md[9]);
        chk("t2_odd03_len", kd, 176);
        chk("t2_odd03_par", 32'(md[9]), 32'h1);
        chk("t2_odd03_data", 32'(md[8:1]), 32'h03);
        repeat (3) cyc();

        // tick every 4th cycle, accepted in a tick cycle
        tick_m = 4;
        for (int j = 0; j < 8 && !s_tick; j++) cyc();
        send(0, 8'h00, -1, kd, md, bc, lr, t0);
        $display("frame d0 m=4 din=00 done_at=%0d low=%0d", kd, lr);
        chk("t3_low_run", lr, 576);
        chk("t3_len", kd, 640);
        tick_m = 1;
        repeat (3) cyc();

        // ignored mid-frame request, then back-to-back in the done cycle
        send(0, 8'h96, 50, kd, md, bc, lr, t0);
        $display("frame d0 din=96 poke@50 done_at=%0d", kd);
        chk("t4_len", kd, 160);
        chk("t4_line", 32'(md[9:0]), 32'({1'b1, 8'h96, 1'b0}));
        send(0, 8'h3C, -1, kd, md, bc, lr, t0);
        $display("frame d0 b2b din=3c done_at=%0d", kd);
        chk("t4_b2b_start", 32'(t0), 32'h0);
        chk("t4_b2b_len", kd, 160);
        chk("t4_b2b_line", 32'(md[9:0]), 32'({1'b1, 8'h3C, 1'b0}));
        repeat (3) cyc();

        // asynchronous reset during data bit 3 (bit 3 of C3 is 0)
        din_v[0]   = 8'hC3;
        start_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        repeat (70) cyc();
        chk("t5_pre_tx", 32'(tx_w[0]), 32'h0);
        #2 reset_n = 1'b0;
        #1;
        $display("reset d0 mid-frame tx=%0d busy=%0d", tx_w[0], busy_w[0]);
        chk("t5_async_tx", 32'(tx_w[0]), 32'h1);
        chk("t5_async_busy", 32'(busy_w[0]), 32'h0);
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("t5_no_done", 32'(done_w[0]), 32'h0);
        end
        reset_n = 1'b1;
        repeat (2) cyc();
        send(0, 8'h5A, -1, kd, md, bc, lr, t0);
        $display("frame d0 din=5a done_at=%0d", kd);
        chk("t5_len", kd, 160);
        chk("t5_line", 32'(md[9:0]), 32'({1'b1, 8'h5A, 1'b0}));
        repeat (3) cyc();

        // two stop bits
        send(3, 8'hA5, -1, kd, md, bc, lr, t0);
        $display("frame d3 sb32 din=a5 done_at=%0d", kd);
        chk("t6_len", kd, 176);
        chk("t6_stop_a", 32'(md[9]), 32'h1);
        chk("t6_stop_b", 32'(md[10]), 32'h1);
        chk("t6_data", 32'(md[8:1]), 32'hA5);
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
